dl_proc_block_monitor: RTL and testbench
========================================

// Module: dl_proc_block_monitor
// PURPOSE
// - Per-process deadlock monitor for HLS co-simulation. One instance sits upstream of the
//   deadlock report unit for each dataflow process.
// - Filters the process's channel-stall indications into its bit of dl_in_vec.
// - After a deadlock is detected, walks the dependence cycle by holding and passing a
//   one-hot token to the peer process it is blocked on.
// PARAMETERS
// - PROC_NUM    2   number of dataflow processes; width of all process vectors.
// - IDX         0   index of this process; 0..PROC_NUM-1.
// - CHAN_NUM    1   number of blocking sources of this process (FIFOs and sync logic).
// - BLK_FILTER  4   consecutive stalled cycles required before dl_in_bit asserts; >=1.
// PORTS
// - dl_clock         in   1                   simulation clock, rising edge.
// - dl_reset         in   1                   reset; asynchronous, active-high.
// - proc_blocked_vec in   CHAN_NUM            bit c=1: process stalled on channel c.
// - chan_peer_vec    in   CHAN_NUM*PROC_NUM   per channel, one-hot peer process (static).
// - dl_detect_in     in   1                   deadlock-detected level from report unit.
// - origin           in   PROC_NUM            one-hot cycle start, valid one cycle.
// - token_in_vec     in   PROC_NUM            OR of all monitors' dep_vec_out.
// - token_clear      in   1                   cycle finished; pulse from report unit.
// - dl_in_bit        out  1                   this process's bit of dl_in_vec.
// - dep_vec_out      out  PROC_NUM            one-hot peer while passing the token, else 0.
// - loop_err         out  1                   sticky: token revisited a passed node.
// - blk_chan_idx     out  $clog2(CHAN_NUM)+1  channel chosen for the pass (trace feature).
// BEHAVIOUR
// - Reset (async, dl_reset=1) values:
//   - state=ST_RUN; all outputs 0; filter counter 0; visited flag 0.
// - blocked = |proc_blocked_vec. Filter counter increments while blocked, saturating at
//   BLK_FILTER; it is cleared in the cycle after blocked falls.
// - ST_RUN
//   - dl_in_bit=1 (registered) once counter==BLK_FILTER and blocked; deasserts the cycle
//     after blocked falls.
//   - dl_detect_in=1 -> ST_WAIT_TOKEN. Counter and dl_in_bit freeze from that point.
// - ST_WAIT_TOKEN (dl_in_bit=0)
//   - Exits when origin[IDX]=1 or token_in_vec[IDX]=1; origin takes priority.
//   - Not visited -> ST_HOLD next cycle.
//   - Visited and not origin -> ST_HOLD with loop_err set.
// - ST_HOLD: exactly one cycle.
//   - dl_in_bit=1; visited <= 1.
//   - Selected channel = lowest-index set bit of proc_blocked_vec.
//   - dep_vec_out = chan_peer_vec slice of the selected channel.
//   - No channel blocked -> dep_vec_out=0 and loop_err set.
//   - -> ST_PASSED.
// - ST_PASSED (dl_in_bit=0): re-accepts the token exactly as ST_WAIT_TOKEN does.
// - token_clear=1 in any post-detect state, same cycle as other events:
//   - clears visited; -> ST_WAIT_TOKEN; token_clear wins over token arrival.
// - dl_detect_in=0 in any post-detect state -> ST_RUN; clears counter and visited.
// - Latency:
//   - Token arrival -> dl_in_bit/dep_vec_out high: 1 cycle.
//   - Peer monitor receives the token 1 cycle later.
// - Mid-operation reset returns to reset values immediately; no pending token survives.
// CONFIGURATION
// - DL_MON_CHAN_TRACE_EN defined:
//   - blk_chan_idx = selected channel index + 1, registered with ST_HOLD; 0 = none.
//   - $display of IDX, channel and peer at each pass.
// - Not defined: blk_chan_idx tied 0; no $display.
// STRUCTURE
// - Package dl_mon_pkg:
//   - state enum {ST_RUN, ST_WAIT_TOKEN, ST_HOLD, ST_PASSED};
//   - idx_w(PROC_NUM) width function;
//   - onehot_sel() slice helper.
// - Sub-module dl_mon_prio_enc: CHAN_NUM-wide lowest-set-bit encoder; outputs valid and index.
// TESTING
// - T1 filter: blocked 3 cycles, BLK_FILTER=4 -> dl_in_bit stays 0; held 4 -> 1;
//   blocked falls -> 0 the next cycle.
// - T2 origin: dl_detect_in=1, origin[IDX]=1, proc_blocked_vec=2'b10 with peer 1 on ch1
//   -> next cycle dl_in_bit=1, dep_vec_out=2'b10 for 1 cycle.
// - T3 two-instance ring (PROC_NUM=2):
//   - token goes 0->1->0; dep_vec_out pulses alternate one cycle apart;
//   - token_clear returns both to ST_WAIT_TOKEN; loop_err=0.
// - T4 revisit: non-origin node gets token twice with no token_clear
//   -> loop_err=1 sticky; it passes again.
// - T5 simultaneous: token_in_vec[IDX]=1 with token_clear=1 -> no ST_HOLD; dl_in_bit stays 0.
// - T6 reset mid-ST_HOLD: dl_reset pulse -> outputs 0 asynchronously; state ST_RUN;
//   loop_err cleared.

Source files
------------

// File: rtl/dl_mon_pkg.sv
// Shared types and helpers for the per-process deadlock monitor.
package dl_mon_pkg;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_WAIT_TOKEN,
      ST_HOLD,
      ST_PASSED
   } state_e;

   // Upper bound on CHAN_NUM*PROC_NUM accepted by onehot_sel.
   localparam int unsigned MaxVecW = 256;

   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Returns the w-bit slice number sel of vec, zero-extended.
   function automatic logic [MaxVecW-1:0] onehot_sel(input logic [MaxVecW-1:0] vec,
                                                     input int unsigned sel,
                                                     input int unsigned w);
      logic [MaxVecW-1:0] mask;
      mask = ~({MaxVecW{1'b1}} << w);
      return (vec >> (sel * w)) & mask;
   endfunction

endpackage

// File: rtl/dl_mon_prio_enc.sv
// Lowest-set-bit priority encoder over the channel-stall vector.
module dl_mon_prio_enc
   import dl_mon_pkg::*;
#(
   parameter int unsigned N    = 1,
   parameter int unsigned IdxW = idx_w(N)
) (
   input  logic [N-1:0]    req_i,
   output logic            valid_o,
   output logic [IdxW-1:0] idx_o
);

   always_comb begin
      valid_o = 1'b0;
      idx_o   = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (req_i[i] && !valid_o) begin
            valid_o = 1'b1;
            idx_o   = IdxW'(i);
         end
      end
   end

endmodule

// File: rtl/dl_proc_block_monitor.sv
// Per-process deadlock monitor: stall filter plus dependence-cycle token walker.
// Optional channel trace output and pass logging enabled by DL_MON_CHAN_TRACE_EN.
module dl_proc_block_monitor
   import dl_mon_pkg::*;
#(
   parameter int unsigned PROC_NUM   = 2,
   parameter int unsigned IDX        = 0,
   parameter int unsigned CHAN_NUM   = 1,
   parameter int unsigned BLK_FILTER = 4
) (
   input  logic                         dl_clock,
   input  logic                         dl_reset,
   input  logic [CHAN_NUM-1:0]          proc_blocked_vec,
   input  logic [CHAN_NUM*PROC_NUM-1:0] chan_peer_vec,
   input  logic                         dl_detect_in,
   input  logic [PROC_NUM-1:0]          origin,
   input  logic [PROC_NUM-1:0]          token_in_vec,
   input  logic                         token_clear,
   output logic                         dl_in_bit,
   output logic [PROC_NUM-1:0]          dep_vec_out,
   output logic                         loop_err,
   output logic [$clog2(CHAN_NUM):0]    blk_chan_idx
);

   localparam int unsigned CntW   = $clog2(BLK_FILTER + 1);
   localparam int unsigned ChIdxW = idx_w(CHAN_NUM);
   localparam int unsigned TraceW = $clog2(CHAN_NUM) + 1;

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                filt_q, filt_d;
   logic                visited_q, visited_d;
   logic                loop_err_q, loop_err_d;
   logic [PROC_NUM-1:0] dep_q, dep_d;

   logic                blocked;
   logic                tok_hit;
   logic                enter_hold;
   logic                sel_valid;
   logic [ChIdxW-1:0]   sel_idx;
   logic [PROC_NUM-1:0] sel_peer;
   logic                unused_tok;

   assign blocked    = |proc_blocked_vec;
   assign tok_hit    = origin[IDX] | token_in_vec[IDX];
   assign unused_tok = ^{origin, token_in_vec};

   dl_mon_prio_enc #(
      .N    (CHAN_NUM),
      .IdxW (ChIdxW)
   ) u_prio_enc (
      .req_i   (proc_blocked_vec),
      .valid_o (sel_valid),
      .idx_o   (sel_idx)
   );

   assign sel_peer = PROC_NUM'(onehot_sel(MaxVecW'(chan_peer_vec), 32'(sel_idx), PROC_NUM));

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      filt_d     = filt_q;
      visited_d  = visited_q;
      loop_err_d = loop_err_q;
      dep_d      = '0;
      enter_hold = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            // Filter state freezes once a deadlock has been reported.
            if (dl_detect_in) begin
               state_d = ST_WAIT_TOKEN;
            end else if (blocked) begin
               if (cnt_q != CntW'(BLK_FILTER)) cnt_d = cnt_q + 1'b1;
               filt_d = (cnt_d == CntW'(BLK_FILTER));
            end else begin
               cnt_d  = '0;
               filt_d = 1'b0;
            end
         end
         default: begin
            if (!dl_detect_in) begin
               state_d   = ST_RUN;
               cnt_d     = '0;
               filt_d    = 1'b0;
               visited_d = 1'b0;
            end else if (token_clear) begin
               state_d   = ST_WAIT_TOKEN;
               visited_d = 1'b0;
            end else if (state_q == ST_HOLD) begin
               state_d   = ST_PASSED;
               visited_d = 1'b1;
            end else if (tok_hit) begin
               state_d    = ST_HOLD;
               enter_hold = 1'b1;
               if (visited_q && !origin[IDX]) loop_err_d = 1'b1;
            end
         end
      endcase
      // Channel choice is captured on entry so dep_vec_out is registered for the HOLD cycle.
      if (enter_hold) begin
         if (sel_valid) dep_d = sel_peer;
         else           loop_err_d = 1'b1;
      end
   end

   always_ff @(posedge dl_clock or posedge dl_reset) begin
      if (dl_reset) begin
         state_q    <= ST_RUN;
         cnt_q      <= '0;
         filt_q     <= 1'b0;
         visited_q  <= 1'b0;
         loop_err_q <= 1'b0;
         dep_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         filt_q     <= filt_d;
         visited_q  <= visited_d;
         loop_err_q <= loop_err_d;
         dep_q      <= dep_d;
      end
   end

   assign dl_in_bit   = (state_q == ST_RUN) ? filt_q : (state_q == ST_HOLD);
   assign dep_vec_out = dep_q;
   assign loop_err    = loop_err_q;

`ifdef DL_MON_CHAN_TRACE_EN
   logic [TraceW-1:0] trace_q, trace_d;

   always_comb begin
      trace_d = '0;
      if (enter_hold && sel_valid) trace_d = TraceW'(sel_idx) + TraceW'(1);
   end

   always_ff @(posedge dl_clock or posedge dl_reset) begin
      if (dl_reset) trace_q <= '0;
      else          trace_q <= trace_d;
   end

   always_ff @(posedge dl_clock) begin
      if (!dl_reset && state_q == ST_HOLD && trace_q != '0) begin
         $display("dl_mon[%0d]: pass via channel %0d to peer %b", IDX, trace_q - 1'b1, dep_q);
      end
   end

   assign blk_chan_idx = trace_q;
`else
   assign blk_chan_idx = '0;
`endif

endmodule

// File: tb/tb_dl_proc_block_monitor.sv
// Directed bench for dl_proc_block_monitor: two monitors in a PROC_NUM=2 ring.
module tb_dl_proc_block_monitor;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] blk0, blk1;
   logic       detect;
   logic [1:0] origin;
   logic [1:0] tb_tok;
   logic       ring_en;
   logic       clr;
   logic [1:0] token_in;
   logic       dl0, dl1, le0, le1;
   logic [1:0] dep0, dep1;
   logic [1:0] trc0, trc1;
   logic [3:0] peers;
   logic [7:0] obs;

   int vectors     = 0;
   int miscompares = 0;
   string      tag_q[$];
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   // ch0 -> process 0, ch1 -> process 1
   assign peers    = 4'b1001;
   assign token_in = ring_en ? (dep0 | dep1) : tb_tok;
   assign obs      = {le1, le0, dep1, dep0, dl1, dl0};

   dl_proc_block_monitor #(
      .PROC_NUM   (2),
      .IDX        (0),
      .CHAN_NUM   (2),
      .BLK_FILTER (4)
   ) u_mon0 (
      .dl_clock         (clk),
      .dl_reset         (rst),
      .proc_blocked_vec (blk0),
      .chan_peer_vec    (peers),
      .dl_detect_in     (detect),
      .origin           (origin),
      .token_in_vec     (token_in),
      .token_clear      (clr),
      .dl_in_bit        (dl0),
      .dep_vec_out      (dep0),
      .loop_err         (le0),
      .blk_chan_idx     (trc0)
   );

   dl_proc_block_monitor #(
      .PROC_NUM   (2),
      .IDX        (1),
      .CHAN_NUM   (2),
      .BLK_FILTER (4)
   ) u_mon1 (
      .dl_clock         (clk),
      .dl_reset         (rst),
      .proc_blocked_vec (blk1),
      .chan_peer_vec    (peers),
      .dl_detect_in     (detect),
      .origin           (origin),
      .token_in_vec     (token_in),
      .token_clear      (clr),
      .dl_in_bit        (dl1),
      .dep_vec_out      (dep1),
      .loop_err         (le1),
      .blk_chan_idx     (trc1)
   );

   task automatic push(input string tag, input logic [7:0] e);
      tag_q.push_back(tag);
      exp_q.push_back(e);
   endtask

   task automatic pop_check();
      string      t;
      logic [7:0] e;
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      assert (obs === e)
      else begin
         miscompares++;
         $error("FAIL %s: observed {le1,le0,dep1,dep0,dl1,dl0}=%b expected=%b", t, obs, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input string tag, input logic [7:0] e);
      push(tag, e);
      tick();
      pop_check();
   endtask

   initial begin
      rst = 1'b1; blk0 = '0; blk1 = '0; detect = 1'b0; origin = '0;
      tb_tok = '0; ring_en = 1'b0; clr = 1'b0;
      step("reset", 8'h00);
      tick();
      rst = 1'b0;

      // T1 stall filter
      blk0 = 2'b01; tick(); tick();
      step("t1_3cyc", 8'h00);
      blk0 = 2'b00; step("t1_gap", 8'h00);
      blk0 = 2'b01; tick(); tick();
      step("t1_3cyc_again", 8'h00);
      step("t1_4cyc", 8'h01);
      step("t1_sat", 8'h01);
      blk0 = 2'b00; step("t1_fall", 8'h00);

      // T2 origin pass
      blk0 = 2'b10; blk1 = 2'b01; detect = 1'b1;
      step("t2_detect", 8'h00);
      origin = 2'b01; step("t2_hold", 8'h09);
      origin = 2'b00; step("t2_passed", 8'h00);
      clr = 1'b1; step("t2_clear", 8'h00);
      clr = 1'b0;

      // T3 ring 0 -> 1 -> 0, closed by token_clear
      ring_en = 1'b1;
      origin = 2'b01; step("t3_hold0", 8'h09);
      origin = 2'b00; step("t3_hold1", 8'h12);
      clr = 1'b1; step("t3_close", 8'h00);
      clr = 1'b0; step("t3_idle", 8'h00);
      ring_en = 1'b0;

      // T4 revisit on non-origin node 1
      tb_tok = 2'b10; step("t4_first", 8'h12);
      tb_tok = 2'b00; step("t4_passed", 8'h00);
      tb_tok = 2'b10; step("t4_revisit", 8'h92);
      tb_tok = 2'b00; step("t4_sticky", 8'h80);
      clr = 1'b1; step("t4_clear", 8'h80);
      clr = 1'b0;

      // T5 token_clear beats token arrival
      tb_tok = 2'b01; clr = 1'b1; step("t5_clear_wins", 8'h80);
      tb_tok = 2'b00; clr = 1'b0; step("t5_no_hold", 8'h80);

      // T6 asynchronous reset during HOLD
      tb_tok = 2'b01; step("t6_hold", 8'h89);
      tb_tok = 2'b00;
      #2 rst = 1'b1;
      #1 push("t6_async_reset", 8'h00);
      pop_check();
      detect = 1'b0;
      tick();
      rst = 1'b0;
      tick(); tick();
      step("t6_run_3cyc", 8'h00);
      step("t6_run_4cyc", 8'h03);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
